// File: rtl/uart_alu_ctrl_if.sv
// Byte-stream bundle between the UART ALU sequencer and the uart RX/TX AXI-stream ports.
// The slave side is the sequencer; the master side is the uart (or a testbench standing in for it).
interface uart_alu_ctrl_if;
   logic [7:0] rx_tdata_i;
   logic       rx_tvalid_i;
   logic       rx_tready_o;
   logic [7:0] tx_tdata_o;
   logic       tx_tvalid_o;
   logic       tx_tready_i;

   modport slave (
      input  rx_tdata_i,
      input  rx_tvalid_i,
      output rx_tready_o,
      output tx_tdata_o,
      output tx_tvalid_o,
      input  tx_tready_i
   );

   modport master (
      output rx_tdata_i,
      output rx_tvalid_i,
      input  rx_tready_o,
      input  tx_tdata_o,
      input  tx_tvalid_o,
      output tx_tready_i
   );
endinterface

// File: rtl/uart_alu_ctrl.sv
// UART ALU packet sequencer: parses [opcode, reserved, len_lo, len_hi, payload...]
// from the uart RX stream and answers with echoed bytes or a 32-bit add/mul result.
module uart_alu_ctrl #(
   parameter logic [7:0] OP_ECHO = 8'hEC,
   parameter logic [7:0] OP_ADD  = 8'hAD,
   parameter logic [7:0] OP_MUL  = 8'h88
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   uart_alu_ctrl_if.slave        bus,
   output logic                  busy_o,
   output logic                  err_o
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RSVD,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_ECHO,
      ST_OPER,
      ST_RESULT,
      ST_DRAIN
   } state_t;

   state_t      state_q, state_d;

   logic [7:0]  opcode_q;
   logic [7:0]  len_lo_q;
   logic [15:0] cnt_q;
   logic [23:0] op_q;
   logic [1:0]  byte_idx_q;
   logic        first_q;
   logic [31:0] acc_q;
   logic [1:0]  res_idx_q;
   logic [7:0]  tx_data_q;
   logic        tx_valid_q;
   logic        err_q;
   logic        err_d;

   logic        rx_ready;
   logic        rx_fire;
   logic        tx_fire;
   logic [15:0] len_full;
   logic [15:0] pay_len;
   logic        op_known;
   logic        pay_bad;
   logic [31:0] operand;
   logic [31:0] prod;
   logic [31:0] acc_next;

   // Reset holds the stream ready low so nothing is consumed while the block is being cleared.
   assign bus.rx_tready_o = rx_ready & ~rst_ni;
   assign bus.tx_tdata_o  = tx_data_q;
   assign bus.tx_tvalid_o = tx_valid_q;
   assign busy_o          = (state_q != ST_IDLE) & ~rst_ni;
   assign err_o           = err_q;

   assign rx_fire  = bus.rx_tvalid_i & bus.rx_tready_o;
   assign tx_fire  = tx_valid_q & bus.tx_tready_i;

   assign len_full = {bus.rx_tdata_i, len_lo_q};
   assign pay_len  = len_full - 16'd4;
   assign op_known = (opcode_q == OP_ECHO) || (opcode_q == OP_ADD) || (opcode_q == OP_MUL);
   assign pay_bad  = (pay_len == 16'd0) || (pay_len[1:0] != 2'b00);

   // Operand bytes arrive LSB first; the three earlier bytes sit in op_q.
   assign operand  = {bus.rx_tdata_i, op_q};
   assign prod     = acc_q * operand;
   assign acc_next = first_q ? operand : ((opcode_q == OP_ADD) ? (acc_q + operand) : prod);

   // RX ready per state; ECHO stops taking bytes once its payload is used up so the
   // next packet's opcode stays on the bus until the skid register has drained.
   always_comb begin
      rx_ready = 1'b0;
      case (state_q)
         ST_IDLE, ST_RSVD, ST_LEN_LO, ST_LEN_HI, ST_OPER, ST_DRAIN: rx_ready = 1'b1;
         ST_ECHO:   rx_ready = (cnt_q != 16'd0) && (!tx_valid_q || bus.tx_tready_i);
         default:   rx_ready = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_ni) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode and error flag.
   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE:   if (rx_fire) state_d = ST_RSVD;
         ST_RSVD:   if (rx_fire) state_d = ST_LEN_LO;
         ST_LEN_LO: if (rx_fire) state_d = ST_LEN_HI;
         ST_LEN_HI: begin
            if (rx_fire) begin
               if (len_full < 16'd4) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else if (!op_known) begin
                  err_d   = 1'b1;
                  state_d = (len_full == 16'd4) ? ST_IDLE : ST_DRAIN;
               end else if (opcode_q == OP_ECHO) begin
                  state_d = (pay_len != 16'd0) ? ST_ECHO : ST_IDLE;
               end else if (pay_bad) begin
                  err_d   = 1'b1;
                  state_d = (len_full == 16'd4) ? ST_IDLE : ST_DRAIN;
               end else begin
                  state_d = ST_OPER;
               end
            end
         end
         ST_ECHO:   if ((cnt_q == 16'd0) && tx_fire) state_d = ST_IDLE;
         ST_OPER:   if (rx_fire && (cnt_q == 16'd1)) state_d = ST_RESULT;
         ST_RESULT: if (tx_fire && (res_idx_q == 2'd3)) state_d = ST_IDLE;
         ST_DRAIN:  if (rx_fire && (cnt_q == 16'd1)) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Header latches, payload counter, operand assembly, accumulator and TX skid register.
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         opcode_q   <= '0;
         len_lo_q   <= '0;
         cnt_q      <= '0;
         op_q       <= '0;
         byte_idx_q <= '0;
         first_q    <= 1'b0;
         acc_q      <= '0;
         res_idx_q  <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         err_q <= err_d;
         case (state_q)
            ST_IDLE:   if (rx_fire) opcode_q <= bus.rx_tdata_i;
            ST_LEN_LO: if (rx_fire) len_lo_q <= bus.rx_tdata_i;
            ST_LEN_HI: begin
               if (rx_fire) begin
                  cnt_q      <= pay_len;
                  byte_idx_q <= '0;
                  first_q    <= 1'b1;
               end
            end
            ST_ECHO: begin
               if (rx_fire) begin
                  tx_data_q  <= bus.rx_tdata_i;
                  tx_valid_q <= 1'b1;
                  cnt_q      <= cnt_q - 16'd1;
               end else if (tx_fire) begin
                  tx_valid_q <= 1'b0;
               end
            end
            ST_OPER: begin
               if (rx_fire) begin
                  cnt_q      <= cnt_q - 16'd1;
                  byte_idx_q <= byte_idx_q + 2'd1;
                  op_q       <= {bus.rx_tdata_i, op_q[23:8]};
                  if (byte_idx_q == 2'd3) begin
                     acc_q   <= acc_next;
                     first_q <= 1'b0;
                     if (cnt_q == 16'd1) begin
                        tx_data_q  <= acc_next[7:0];
                        tx_valid_q <= 1'b1;
                        res_idx_q  <= '0;
                     end
                  end
               end
            end
            // acc is shifted down per sent byte so the next byte is always acc[15:8].
            ST_RESULT: begin
               if (tx_fire) begin
                  if (res_idx_q == 2'd3) begin
                     tx_valid_q <= 1'b0;
                  end else begin
                     res_idx_q <= res_idx_q + 2'd1;
                     tx_data_q <= acc_q[15:8];
                     acc_q     <= {8'h00, acc_q[31:8]};
                  end
               end
            end
            ST_DRAIN:  if (rx_fire) cnt_q <= cnt_q - 16'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl: directed packets plus randomized packets,
// compared against a stream-level reference model of the packet protocol.
module tb_uart_alu_ctrl;
   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst_ni;
   logic busy_o;
   logic err_o;

   uart_alu_ctrl_if bus ();

   uart_alu_ctrl dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .bus    (bus),
      .busy_o (busy_o),
      .err_o  (err_o)
   );

   always #5 clk = ~clk;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;
   int unsigned err_cnt     = 0;
   bq_t         tx_q;
   logic        tx_mode_rand = 1'b0;
   logic        tx_force     = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // TX ready: random or forced, updated just after each rising edge.
   initial begin
      bus.tx_tready_i = 1'b0;
      forever begin
         @(posedge clk);
         #3;
         bus.tx_tready_i = tx_mode_rand ? 1'($urandom_range(0, 1)) : tx_force;
      end
   end

   // Mid-cycle monitor: records TX handshakes, counts err pulses, checks hold and pulse width.
   logic       prev_v = 1'b0, prev_r = 1'b0, prev_rst = 1'b1, prev_err = 1'b0;
   logic [7:0] prev_d = 8'h00;
   always @(negedge clk) begin
      if (bus.tx_tvalid_o === 1'b1 && bus.tx_tready_i === 1'b1 && rst_ni === 1'b0)
         tx_q.push_back(bus.tx_tdata_o);
      if (err_o === 1'b1) err_cnt++;
      if (prev_v && !prev_r && !prev_rst) begin
         chk("tx_hold_valid", {31'd0, bus.tx_tvalid_o}, 32'd1);
         chk("tx_hold_data", {24'd0, bus.tx_tdata_o}, {24'd0, prev_d});
      end
      if (prev_err) chk("err_single_pulse", {31'd0, err_o}, 32'd0);
      prev_v   = (bus.tx_tvalid_o === 1'b1);
      prev_r   = (bus.tx_tready_i === 1'b1);
      prev_rst = (rst_ni !== 1'b0);
      prev_err = (err_o === 1'b1);
      prev_d   = bus.tx_tdata_o;
   end

   // Reference model: walks a byte stream packet by packet and returns the expected
   // TX bytes and number of rejected packets.
   function automatic void ref_model(input bq_t s, output bq_t resp, output int unsigned nerr);
      int unsigned i, len, pay, k, word, acc;
      logic [7:0]  op;
      resp = {};
      nerr = 0;
      i    = 0;
      while (i + 4 <= s.size()) begin
         op  = s[i];
         len = s[i+2] + 256 * s[i+3];
         if (len < 4) begin
            nerr++;
            i += 4;
            continue;
         end
         pay = len - 4;
         if (op == 8'hEC) begin
            for (int unsigned j = 0; j < pay; j++) resp.push_back(s[i+4+j]);
         end else if ((op == 8'hAD || op == 8'h88) && pay != 0 && (pay % 4) == 0) begin
            acc = 0;
            for (int unsigned w = 0; w < pay / 4; w++) begin
               k    = i + 4 + 4 * w;
               word = s[k] + 256 * s[k+1] + 65536 * s[k+2] + 16777216 * s[k+3];
               if (w == 0)         acc = word;
               else if (op == 8'hAD) acc = acc + word;
               else                acc = acc * word;
            end
            for (int unsigned b = 0; b < 4; b++) resp.push_back(8'((acc >> (8 * b)) % 256));
         end else begin
            nerr++;
         end
         i += len;
      end
   endfunction

   function automatic bq_t mk(input logic [7:0] op, input int unsigned len, input bq_t pay);
      bq_t r;
      r.push_back(op);
      r.push_back(8'h00);
      r.push_back(8'(len % 256));
      r.push_back(8'(len / 256));
      foreach (pay[i]) r.push_back(pay[i]);
      return r;
   endfunction

   function automatic bq_t rand_bytes(input int unsigned n);
      bq_t r;
      for (int unsigned i = 0; i < n; i++) r.push_back(8'($urandom_range(0, 255)));
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int unsigned n = 0;
      bus.rx_tdata_i  = b;
      bus.rx_tvalid_i = 1'b1;
      @(negedge clk);
      while (bus.rx_tready_o !== 1'b1 && n < 300) begin
         n++;
         @(negedge clk);
      end
      chk("rx_accept_in_time", {31'd0, (n < 300)}, 32'd1);
      tick();
      bus.rx_tvalid_i = 1'b0;
   endtask

   task automatic send_stream(input bq_t s, input bit gaps);
      foreach (s[i]) begin
         send_byte(s[i]);
         if (gaps && $urandom_range(0, 3) == 0) tick();
      end
   endtask

   task automatic wait_idle();
      int unsigned n = 0;
      @(negedge clk);
      while ((busy_o !== 1'b0 || bus.tx_tvalid_o !== 1'b0) && n < 500) begin
         n++;
         @(negedge clk);
      end
      chk("idle_in_time", {31'd0, (n < 500)}, 32'd1);
      tick();
      tick();
   endtask

   task automatic wait_tx_valid();
      int unsigned n = 0;
      @(negedge clk);
      while (bus.tx_tvalid_o !== 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("tx_valid_in_time", {31'd0, (n < 100)}, 32'd1);
      tick();
   endtask

   task automatic run_check(input string tag, input bq_t s, input bit gaps);
      bq_t         exp;
      int unsigned nerr, e0;
      ref_model(s, exp, nerr);
      tx_q.delete();
      e0 = err_cnt;
      send_stream(s, gaps);
      wait_idle();
      chk({tag, "_tx_count"}, tx_q.size(), exp.size());
      foreach (exp[i])
         if (i < tx_q.size()) chk({tag, "_tx_byte"}, {24'd0, tx_q[i]}, {24'd0, exp[i]});
      chk({tag, "_err_count"}, err_cnt - e0, nerr);
      chk({tag, "_busy_after"}, {31'd0, busy_o}, 32'd0);
   endtask

   initial begin
      bq_t         p, s, exp;
      int unsigned nerr, kind, n;
      logic [7:0]  op;

      rst_ni          = 1'b1;
      bus.rx_tvalid_i = 1'b0;
      bus.rx_tdata_i  = 8'h00;

      // Reset state.
      repeat (3) tick();
      @(negedge clk);
      chk("rst_rx_tready", {31'd0, bus.rx_tready_o}, 32'd0);
      chk("rst_tx_tvalid", {31'd0, bus.tx_tvalid_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      tick();
      rst_ni = 1'b0;
      @(negedge clk);
      chk("idle_rx_tready", {31'd0, bus.rx_tready_o}, 32'd1);
      chk("idle_busy", {31'd0, busy_o}, 32'd0);
      tick();

      // Echo with random TX back-pressure.
      tx_mode_rand = 1'b1;
      p = {8'h41, 8'h42, 8'h43};
      run_check("echo", mk(8'hEC, 7, p), 1'b1);

      // Add wrapping to zero.
      p = {8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      run_check("add_wrap", mk(8'hAD, 12, p), 1'b1);

      // Multiply with TX stalled for 10 cycles.
      tx_mode_rand = 1'b0;
      tx_force     = 1'b0;
      tx_q.delete();
      p = {8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
      send_stream(mk(8'h88, 12, p), 1'b0);
      wait_tx_valid();
      repeat (10) begin
         @(negedge clk);
         chk("mul_stall_valid", {31'd0, bus.tx_tvalid_o}, 32'd1);
         chk("mul_stall_data", {24'd0, bus.tx_tdata_o}, 32'h0F);
         chk("mul_stall_rx_tready", {31'd0, bus.rx_tready_o}, 32'd0);
      end
      tick();
      tx_mode_rand = 1'b1;
      wait_idle();
      exp = {8'h0F, 8'h00, 8'h00, 8'h00};
      chk("mul_tx_count", tx_q.size(), 4);
      foreach (exp[i])
         if (i < tx_q.size()) chk("mul_tx_byte", {24'd0, tx_q[i]}, {24'd0, exp[i]});

      // Unknown opcode is drained, then an echo still works.
      p = {8'hAA, 8'hBB};
      run_check("bad_opcode", mk(8'h55, 6, p), 1'b1);
      p = {8'h7E};
      run_check("echo_after_bad", mk(8'hEC, 5, p), 1'b1);

      // Add with a payload that is not a multiple of 4.
      run_check("bad_len_drain", mk(8'hAD, 10, rand_bytes(6)), 1'b1);

      // Length boundaries: len < 4, and len == 4 for each opcode class.
      p = {};
      s = {mk(8'hAD, 3, p), mk(8'hEC, 4, p), mk(8'h88, 4, p), mk(8'h12, 4, p), mk(8'hEC, 5, rand_bytes(1))};
      run_check("len_edges", s, 1'b0);

      // Reset in RESULT after two of four bytes have gone out.
      tx_mode_rand = 1'b0;
      tx_force     = 1'b0;
      tx_q.delete();
      s = mk(8'hAD, 12, rand_bytes(8));
      ref_model(s, exp, nerr);
      send_stream(s, 1'b0);
      wait_tx_valid();
      tx_force = 1'b1;
      tick();
      tick();
      tx_force = 1'b0;
      rst_ni   = 1'b1;
      tick();
      @(negedge clk);
      chk("rst_mid_tx_tvalid", {31'd0, bus.tx_tvalid_o}, 32'd0);
      tick();
      rst_ni = 1'b0;
      @(negedge clk);
      chk("rst_mid_tx_tvalid_after", {31'd0, bus.tx_tvalid_o}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_mid_sent_count", tx_q.size(), 2);
      for (int i = 0; i < 2; i++)
         if (i < tx_q.size()) chk("rst_mid_sent_byte", {24'd0, tx_q[i]}, {24'd0, exp[i]});
      tick();
      tx_mode_rand = 1'b1;
      p = {8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      run_check("add_wrap_after_rst", mk(8'hAD, 12, p), 1'b1);

      // Randomized packets.
      repeat (24) begin
         kind = $urandom_range(0, 4);
         case (kind)
            0: begin
               n = $urandom_range(0, 6);
               s = mk(8'hEC, 4 + n, rand_bytes(n));
            end
            1, 2: begin
               n = 4 * $urandom_range(1, 3);
               s = mk((kind == 1) ? 8'hAD : 8'h88, 4 + n, rand_bytes(n));
            end
            3: begin
               op = 8'($urandom_range(0, 255));
               while (op == 8'hEC || op == 8'hAD || op == 8'h88) op = 8'($urandom_range(0, 255));
               n = $urandom_range(0, 5);
               s = mk(op, 4 + n, rand_bytes(n));
            end
            default: begin
               n = $urandom_range(1, 7);
               if (n % 4 == 0) n = n + 1;
               s = mk(($urandom_range(0, 1) == 1) ? 8'hAD : 8'h88, 4 + n, rand_bytes(n));
            end
         endcase
         run_check("random", s, 1'b1);
      end

      // Back-to-back packets with no idle gap.
      s = {mk(8'h88, 12, rand_bytes(8)), mk(8'hEC, 7, rand_bytes(3)), mk(8'hAD, 16, rand_bytes(12))};
      run_check("back_to_back", s, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
